// File: rtl/cpuy_pkg.sv
// cpuy_pkg: shared CPU widths, call/return sequencer states and fault codes.
package cpuy_pkg;
    localparam int CPU_AW = 10;
    typedef enum logic [2:0] {IDLE, PUSH, POP, LOAD, FAULT} crc_state_t;
    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UNF  = 2'b10;
endpackage

// File: rtl/call_ret_ctrl.sv
// call_ret_ctrl: turns CALL/RET requests into return-stack push/pop and PC loads.
// Define CRC_IRQ_EN to add interrupt entry (irq_req/irq_ack) and reti_req.
module call_ret_ctrl
    import cpuy_pkg::*;
#(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = 16,
    parameter int DW    = $clog2(DEPTH) + 1
`ifdef CRC_IRQ_EN
    ,
    parameter logic [AW-1:0] IRQ_VECTOR = AW'('h3F0)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic [AW-1:0] ret_addr,
    input  logic [AW-1:0] target,
    output logic          busy,
    output logic          pc_load,
    output logic [AW-1:0] pc_value,
    output logic          stk_enable,
    output logic          stk_push,
    output logic [AW-1:0] stk_data,
    input  logic [AW-1:0] stk_rdata,
    input  logic          stk_full,
    input  logic          stk_empty,
    output logic [DW-1:0] depth,
    output logic          fault,
    output logic [1:0]    fault_code,
`ifdef CRC_IRQ_EN
    input  logic          irq_req,
    input  logic          reti_req,
    output logic          irq_ack,
`endif
    input  logic          fault_clr
);
    crc_state_t    state_q, state_d;
    logic [AW-1:0] ra_q, ra_d, tgt_q, tgt_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    code_q, code_d;
    logic          irq_go, ret_go;
`ifdef CRC_IRQ_EN
    logic          in_isr_q, in_isr_d, irq_q, irq_d, reti_q, reti_d;
    assign irq_go = irq_req & ~in_isr_q;
    assign ret_go = ret_req | reti_req;
`else
    assign irq_go = 1'b0;
    assign ret_go = ret_req;
`endif

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        tgt_d   = tgt_q;
        depth_d = depth_q;
        code_d  = code_q;
`ifdef CRC_IRQ_EN
        in_isr_d = in_isr_q;
        irq_d    = irq_q;
        reti_d   = reti_q;
`endif
        case (state_q)
            IDLE: begin
                if (irq_go || call_req) begin
                    if (stk_full) begin
                        state_d = FAULT;
                        code_d  = FLT_OVF;
                    end else begin
                        state_d = PUSH;
                        ra_d    = ret_addr;
                        tgt_d   = target;
                        depth_d = depth_q + DW'(1);
`ifdef CRC_IRQ_EN
                        irq_d = irq_go;
                        if (irq_go) begin
                            tgt_d    = IRQ_VECTOR;
                            in_isr_d = 1'b1;
                        end
`endif
                    end
                end else if (ret_go) begin
                    if (stk_empty) begin
                        state_d = FAULT;
                        code_d  = FLT_UNF;
                    end else begin
                        state_d = POP;
                        depth_d = depth_q - DW'(1);
`ifdef CRC_IRQ_EN
                        reti_d = reti_req;
`endif
                    end
                end
            end
            PUSH: state_d = IDLE;
            POP:  state_d = LOAD;
            LOAD: begin
                state_d = IDLE;
`ifdef CRC_IRQ_EN
                if (reti_q) in_isr_d = 1'b0;
`endif
            end
            FAULT: begin
                state_d = fault_clr ? IDLE : FAULT;
                code_d  = fault_clr ? FLT_NONE : code_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            tgt_q   <= '0;
            depth_q <= '0;
            code_q  <= FLT_NONE;
`ifdef CRC_IRQ_EN
            in_isr_q <= 1'b0;
            irq_q    <= 1'b0;
            reti_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            tgt_q   <= tgt_d;
            depth_q <= depth_d;
            code_q  <= code_d;
`ifdef CRC_IRQ_EN
            in_isr_q <= in_isr_d;
            irq_q    <= irq_d;
            reti_q   <= reti_d;
`endif
        end
    end

    // stk_rdata is the stack's own output register, valid exactly in LOAD
    assign busy       = state_q != IDLE;
    assign pc_load    = (state_q == PUSH) || (state_q == LOAD);
    assign pc_value   = (state_q == PUSH) ? tgt_q : (state_q == LOAD) ? stk_rdata : '0;
    assign stk_enable = (state_q == PUSH) || (state_q == POP);
    assign stk_push   = state_q == PUSH;
    assign stk_data   = (state_q == PUSH) ? ra_q : '0;
    assign depth      = depth_q;
    assign fault      = state_q == FAULT;
    assign fault_code = code_q;
`ifdef CRC_IRQ_EN
    assign irq_ack    = (state_q == PUSH) && irq_q;
`endif
endmodule

// File: tb/tb_call_ret_ctrl.sv
// tb_call_ret_ctrl: directed bench with a behavioural return stack and a pc_load scoreboard.
module tb_call_ret_ctrl;
    localparam int AW = 10;
    localparam int DEPTH = 16;
    localparam int DW = 5;

    logic          clk = 1'b0, rst = 1'b1;
    logic          call_req = 1'b0, ret_req = 1'b0, fault_clr = 1'b0;
    logic [AW-1:0] ret_addr = '0, target = '0;
    logic          busy, pc_load, stk_enable, stk_push, stk_full, stk_empty, fault;
    logic [AW-1:0] pc_value, stk_data, stk_rdata;
    logic [DW-1:0] depth;
    logic [1:0]    fault_code;
`ifdef CRC_IRQ_EN
    logic          irq_req = 1'b0, reti_req = 1'b0, irq_ack;
`endif

    always #5 clk = ~clk;

    call_ret_ctrl #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .ret_addr(ret_addr), .target(target), .busy(busy), .pc_load(pc_load),
        .pc_value(pc_value), .stk_enable(stk_enable), .stk_push(stk_push),
        .stk_data(stk_data), .stk_rdata(stk_rdata), .stk_full(stk_full),
        .stk_empty(stk_empty), .depth(depth), .fault(fault), .fault_code(fault_code),
`ifdef CRC_IRQ_EN
        .irq_req(irq_req), .reti_req(reti_req), .irq_ack(irq_ack),
`endif
        .fault_clr(fault_clr)
    );

    // Return stack: full at sp==DEPTH-1, registered read data after a pop
    logic [AW-1:0] mem [DEPTH];
    logic [3:0]    sp;
    assign stk_full  = sp == 4'(DEPTH - 1);
    assign stk_empty = sp == 4'd0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
            stk_rdata <= '0;
        end else if (stk_enable) begin
            if (stk_push && !stk_full) begin
                mem[sp] <= stk_data;
                sp <= sp + 4'd1;
            end else if (!stk_push && !stk_empty) begin
                stk_rdata <= mem[sp - 4'd1];
                sp <= sp - 4'd1;
            end
        end
    end

    typedef struct { logic [AW-1:0] pc; int d; } exp_t;
    exp_t          sbq[$];
    logic [AW-1:0] mstk[$];
    int            mdepth = 0;
    int            errors = 0, checks = 0, en_cnt = 0, e0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {busy, pc_load, pc_value, stk_enable, stk_push, stk_data, depth, fault, fault_code};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (stk_enable) en_cnt++;
        if (pc_load) begin
            if (sbq.size() == 0) chk("pc_load_unexpected", {31'd0, pc_load}, 32'd0);
            else begin
                e = sbq.pop_front();
                chk("pc_value", {22'd0, pc_value}, {22'd0, e.pc});
                chk("depth_at_load", {27'd0, depth}, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sbq.size() != 0; i++) tick();
        chk("sb_drain", sbq.size(), 0);
    endtask

    task automatic do_call(input logic [AW-1:0] ra, input logic [AW-1:0] tg, input logic also_ret);
        mstk.push_back(ra);
        mdepth++;
        sbq.push_back('{pc: tg, d: mdepth});
        ret_addr = ra;
        target = tg;
        call_req = 1'b1;
        ret_req = also_ret;
        tick();
        call_req = 1'b0;
        ret_req = 1'b0;
        tick();
    endtask

    task automatic do_ret(input logic use_reti);
        logic [AW-1:0] r;
        r = mstk.pop_back();
        mdepth--;
        sbq.push_back('{pc: r, d: mdepth});
`ifdef CRC_IRQ_EN
        reti_req = use_reti;
        ret_req = !use_reti;
`else
        ret_req = 1'b1;
`endif
        tick();
        ret_req = 1'b0;
`ifdef CRC_IRQ_EN
        reti_req = 1'b0;
`endif
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("idle_outputs", outs(), 32'd0);
        // Underflow from empty stack
        e0 = en_cnt;
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk("unf_fault", {31'd0, fault}, 32'd1);
        chk("unf_code", {30'd0, fault_code}, 32'd2);
        repeat (3) tick();
        chk("unf_held", {31'd0, busy & fault}, 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("unf_cleared", outs(), 32'd0);
        chk("unf_no_stack_traffic", en_cnt - e0, 0);
        // Single call then ret
        do_call(10'h045, 10'h120, 1'b0);
        drain();
        chk("call_depth", {27'd0, depth}, 32'd1);
        do_ret(1'b0);
        drain();
        chk("ret_depth", {27'd0, depth}, 32'd0);
        // Fill the stack
        for (int i = 1; i <= 15; i++) do_call(AW'(i), AW'(10'h200 + i), 1'b0);
        drain();
        chk("nest_depth", {27'd0, depth}, 32'd15);
        chk("nest_full", {31'd0, stk_full}, 32'd1);
        // Overflow
        e0 = en_cnt;
        ret_addr = 10'h3FF;
        target = 10'h155;
        call_req = 1'b1;
        tick();
        call_req = 1'b0;
        chk("ovf_fault", {31'd0, fault}, 32'd1);
        chk("ovf_code", {30'd0, fault_code}, 32'd1);
        tick();
        chk("ovf_no_stack_traffic", en_cnt - e0, 0);
        chk("ovf_stack_unchanged", {28'd0, sp}, 32'd15);
        chk("ovf_depth", {27'd0, depth}, 32'd15);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("ovf_cleared", {29'd0, busy, fault_code}, 32'd0);
        for (int i = 0; i < 15; i++) do_ret(1'b0);
        drain();
        chk("unnest_depth", {27'd0, depth}, 32'd0);
        // Simultaneous call+ret at depth 2
        do_call(10'h011, 10'h0A1, 1'b0);
        do_call(10'h022, 10'h0A2, 1'b0);
        do_call(10'h033, 10'h0A3, 1'b1);
        drain();
        chk("simul_depth", {27'd0, depth}, 32'd3);
        chk("simul_sp", {28'd0, sp}, 32'd3);
        for (int i = 0; i < 3; i++) do_ret(1'b0);
        drain();
        // Reset while in POP
        do_call(10'h0AB, 10'h321, 1'b0);
        drain();
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk("pop_state", {30'd0, busy, stk_enable}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_in_pop", outs(), 32'd0);
        mstk.delete();
        mdepth = 0;
        @(negedge clk) rst = 1'b0;
        tick();
        do_call(10'h0AA, 10'h111, 1'b0);
        drain();
        chk("post_rst_slot0", {22'd0, mem[0]}, 32'h0AA);
        chk("post_rst_sp", {28'd0, sp}, 32'd1);
        do_ret(1'b0);
        drain();
`ifdef CRC_IRQ_EN
        // Interrupt entry, masking and reti
        mstk.push_back(10'h077);
        mdepth++;
        sbq.push_back('{pc: 10'h3F0, d: mdepth});
        ret_addr = 10'h077;
        irq_req = 1'b1;
        tick();
        irq_req = 1'b0;
        chk("irq_ack", {31'd0, irq_ack}, 32'd1);
        chk("irq_vector", {22'd0, pc_value}, 32'h3F0);
        tick();
        drain();
        irq_req = 1'b1;
        tick();
        irq_req = 1'b0;
        chk("irq_masked", {30'd0, busy, irq_ack}, 32'd0);
        do_ret(1'b1);
        drain();
        mstk.push_back(10'h078);
        mdepth++;
        sbq.push_back('{pc: 10'h3F0, d: mdepth});
        ret_addr = 10'h078;
        irq_req = 1'b1;
        tick();
        irq_req = 1'b0;
        chk("irq_after_reti", {31'd0, irq_ack}, 32'd1);
        tick();
        do_ret(1'b1);
        drain();
`endif
        chk("final_depth", {27'd0, depth}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
